// File: rtl/arcade_iir_filter_if.sv
// Bundle between the audio mix and the stereo IIR filter.
// Master drives coefficients and samples; slave returns filtered audio.
interface arcade_iir_filter_if;
   logic [31:0] flt_rate;
   logic [39:0] cx;
   logic [7:0]  cx0;
   logic [7:0]  cx1;
   logic [7:0]  cx2;
   logic [23:0] cy0;
   logic [23:0] cy1;
   logic [23:0] cy2;
   logic [15:0] in_l;
   logic [15:0] in_r;
   logic [15:0] out_l;
   logic [15:0] out_r;
   logic        out_valid;
   logic        overrun;

   modport master (
      output flt_rate, cx, cx0, cx1, cx2,
      output cy0, cy1, cy2, in_l, in_r,
      input  out_l, out_r, out_valid, overrun
   );

   modport slave (
      input  flt_rate, cx, cx0, cx1, cx2,
      input  cy0, cy1, cy2, in_l, in_r,
      output out_l, out_r, out_valid, overrun
   );
endinterface

// File: rtl/arcade_iir_filter.sv
// Stereo 3rd-order IIR filter with its own sample tick and one shared
// datapath. Ports: clk, reset_n (async low), bus (slave: coefs/in/out).
module arcade_iir_filter #(
   parameter int unsigned CLK_RATE = 74250000,
   parameter int          CX_SHIFT = 42,
   parameter int          CY_SHIFT = 21
) (
   input logic               clk,
   input logic               reset_n,
   arcade_iir_filter_if.slave bus
);

   localparam int GW = 68 - CX_SHIFT;
   localparam int FW = 43 - CY_SHIFT;
   localparam logic [32:0] RATE = 33'(CLK_RATE);

   typedef enum logic [1:0] {IDLE, CALC_L, CALC_R, OUT} state_e;

   state_e                state_q, state_d;
   logic [1:0]            step_q, step_d;
   logic [31:0]           acc_q, acc_d;
   logic [39:0]           cx_q, cx_d;
   logic [7:0]            cx0_q, cx0_d;
   logic [7:0]            cx1_q, cx1_d;
   logic [7:0]            cx2_q, cx2_d;
   logic [23:0]           cy0_q, cy0_d;
   logic [23:0]           cy1_q, cy1_d;
   logic [23:0]           cy2_q, cy2_d;
   logic [1:0][15:0]      xin_q, xin_d;
   logic [1:0][2:0][15:0] x_q, x_d;
   logic [1:0][2:0][15:0] y_q, y_d;
   logic signed [26:0]    xsum_q, xsum_d;
   logic signed [GW-1:0]  g_q, g_d;
   logic signed [FW-1:0]  f_q, f_d;
   logic [15:0]           out_l_q, out_l_d;
   logic [15:0]           out_r_q, out_r_d;
   logic                  out_valid_q, out_valid_d;
   logic                  overrun_q, overrun_d;

   logic [32:0]        sum;
   logic               tick;
   logic               coef_chg;
   logic               ch;
   logic signed [15:0] x0, x1, x2, x3;
   logic signed [15:0] y1, y2, y3;
   logic signed [26:0] xsum_c;
   logic signed [67:0] gp;
   logic signed [41:0] fs;
   logic signed [67:0] d;
   logic [15:0]        y_sat;

   // Rates at or above CLK_RATE tick every cycle and freeze acc,
   // keeping it below CLK_RATE for any flt_rate.
   always_comb begin
      sum  = {1'b0, acc_q} + {1'b0, bus.flt_rate};
      tick = 1'b0;
      acc_d = acc_q;
      if ({1'b0, bus.flt_rate} >= RATE) begin
         tick = 1'b1;
      end else if (sum >= RATE) begin
         tick  = 1'b1;
         acc_d = 32'(sum - RATE);
      end else begin
         acc_d = sum[31:0];
      end
   end

   assign coef_chg =
      {bus.cx, bus.cx0, bus.cx1, bus.cx2,
       bus.cy0, bus.cy1, bus.cy2} !=
      {cx_q, cx0_q, cx1_q, cx2_q,
       cy0_q, cy1_q, cy2_q};

   always_comb begin
      ch = (state_q == CALC_R);
      x0 = $signed(xin_q[ch]);
      x1 = $signed(x_q[ch][0]);
      x2 = $signed(x_q[ch][1]);
      x3 = $signed(x_q[ch][2]);
      y1 = $signed(y_q[ch][0]);
      y2 = $signed(y_q[ch][1]);
      y3 = $signed(y_q[ch][2]);
      xsum_c = 27'(x0)
             + 27'($signed({1'b0, cx0_q})) * 27'(x1)
             + 27'($signed({1'b0, cx1_q})) * 27'(x2)
             + 27'($signed({1'b0, cx2_q})) * 27'(x3);
      gp = 68'($signed({1'b0, cx_q})) * 68'(xsum_q);
      fs = 42'($signed(cy0_q)) * 42'(y1)
         + 42'($signed(cy1_q)) * 42'(y2)
         + 42'($signed(cy2_q)) * 42'(y3);
      d = 68'(g_q) - 68'(f_q);
      if (d > 68'sd32767)
         y_sat = 16'h7fff;
      else if (d < -68'sd32768)
         y_sat = 16'h8000;
      else
         y_sat = d[15:0];
   end

   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      cx_d        = cx_q;
      cx0_d       = cx0_q;
      cx1_d       = cx1_q;
      cx2_d       = cx2_q;
      cy0_d       = cy0_q;
      cy1_d       = cy1_q;
      cy2_d       = cy2_q;
      xin_d       = xin_q;
      x_d         = x_q;
      y_d         = y_q;
      xsum_d      = xsum_q;
      g_d         = g_q;
      f_d         = f_q;
      out_l_d     = out_l_q;
      out_r_d     = out_r_q;
      out_valid_d = 1'b0;
      overrun_d   = overrun_q;
      if (tick && state_q != IDLE)
         overrun_d = 1'b1;
      unique case (state_q)
         IDLE: begin
            if (tick) begin
               xin_d[0] = bus.in_l;
               xin_d[1] = bus.in_r;
               cx_d     = bus.cx;
               cx0_d    = bus.cx0;
               cx1_d    = bus.cx1;
               cx2_d    = bus.cx2;
               cy0_d    = bus.cy0;
               cy1_d    = bus.cy1;
               cy2_d    = bus.cy2;
               // New coefficients start from a clean history.
               if (coef_chg) begin
                  x_d = '0;
                  y_d = '0;
               end
               step_d  = 2'd0;
               state_d = CALC_L;
            end
         end
         CALC_L, CALC_R: begin
            step_d = step_q + 2'd1;
            unique case (step_q)
               2'd0: xsum_d = xsum_c;
               2'd1: g_d = GW'(gp >>> CX_SHIFT);
               2'd2: f_d = FW'(fs >>> CY_SHIFT);
               default: begin
                  x_d[ch] = {x_q[ch][1:0], xin_q[ch]};
                  y_d[ch] = {y_q[ch][1:0], y_sat};
                  if (state_q == CALC_L) begin
                     state_d = CALC_R;
                  end else begin
                     // Left result already sits in y1 of channel 0.
                     state_d     = OUT;
                     out_l_d     = y_q[0][0];
                     out_r_d     = y_sat;
                     out_valid_d = 1'b1;
                  end
               end
            endcase
         end
         OUT:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         step_q      <= '0;
         acc_q       <= '0;
         cx_q        <= '0;
         cx0_q       <= '0;
         cx1_q       <= '0;
         cx2_q       <= '0;
         cy0_q       <= '0;
         cy1_q       <= '0;
         cy2_q       <= '0;
         xin_q       <= '0;
         x_q         <= '0;
         y_q         <= '0;
         xsum_q      <= '0;
         g_q         <= '0;
         f_q         <= '0;
         out_l_q     <= '0;
         out_r_q     <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         acc_q       <= acc_d;
         cx_q        <= cx_d;
         cx0_q       <= cx0_d;
         cx1_q       <= cx1_d;
         cx2_q       <= cx2_d;
         cy0_q       <= cy0_d;
         cy1_q       <= cy1_d;
         cy2_q       <= cy2_d;
         xin_q       <= xin_d;
         x_q         <= x_d;
         y_q         <= y_d;
         xsum_q      <= xsum_d;
         g_q         <= g_d;
         f_q         <= f_d;
         out_l_q     <= out_l_d;
         out_r_q     <= out_r_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign bus.out_l     = out_l_q;
   assign bus.out_r     = out_r_q;
   assign bus.out_valid = out_valid_q;
   assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_arcade_iir_filter.sv
// Scoreboard bench for arcade_iir_filter.
// Directed vectors with hand-computed outputs, plus rate/overrun runs.
module tb_arcade_iir_filter;

   localparam int unsigned CLK_RATE = 74250000;
   localparam int          CXS      = 38;
   localparam logic [39:0] UNITY    = 40'd1 << CXS;
   localparam logic [39:0] DOUBLE   = 40'd1 << (CXS + 1);
   localparam logic [23:0] NEG_ONE  = 24'hE00000;

   typedef struct {
      logic signed [15:0] l;
      logic signed [15:0] r;
      int                 t;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   mode = 3;
   int   pulses = 0;
   int   last_pulse = 0;
   int   stray = 0;
   int   next_tick = 0;
   int   c0 = 0;
   exp_t sbq[$];

   arcade_iir_filter_if bus_if();

   arcade_iir_filter #(
      .CLK_RATE(CLK_RATE),
      .CX_SHIFT(CXS),
      .CY_SHIFT(21)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string name, int act, int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (bus_if.out_valid) begin
         if (mode == 0) begin
            if (sbq.size() == 0) begin
               check("unexpected_valid", 1, 0);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               check("out_l", int'($signed(bus_if.out_l)), int'(e.l));
               check("out_r", int'($signed(bus_if.out_r)), int'(e.r));
               check("latency", cyc - e.t, 9);
            end
         end else if (mode == 3) begin
            stray++;
         end else begin
            pulses++;
            if (pulses > 1) begin
               if (mode == 1) begin
                  int gap;
                  gap = cyc - last_pulse;
                  checks++;
                  if (gap != 10 && gap != 11) begin
                     failures++;
                     $display("FAIL rate_spacing actual=%0d required=10or11",
                              gap);
                  end
               end else begin
                  check("overrun_spacing", cyc - last_pulse, 10);
               end
            end
            last_pulse = cyc;
         end
      end
   end

   task automatic issue(input logic signed [15:0] il,
                        input logic signed [15:0] ir,
                        input logic signed [15:0] el,
                        input logic signed [15:0] er);
      int t;
      t = next_tick;
      while (cyc < t - 5) begin
         @(posedge clk);
         #1;
      end
      bus_if.in_l = il;
      bus_if.in_r = ir;
      sbq.push_back('{el, er, t});
      next_tick = t + 20;
      while (cyc <= t) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_coef(input logic [39:0] gx,
                           input logic [7:0] a0,
                           input logic [7:0] a1,
                           input logic [23:0] b0);
      bus_if.cx  = gx;
      bus_if.cx0 = a0;
      bus_if.cx1 = a1;
      bus_if.cx2 = 8'd0;
      bus_if.cy0 = b0;
      bus_if.cy1 = 24'd0;
      bus_if.cy2 = 24'd0;
   endtask

   task automatic idle_outputs(string tag);
      check({tag, "_out_l"}, int'(bus_if.out_l), 0);
      check({tag, "_out_r"}, int'(bus_if.out_r), 0);
      check({tag, "_valid"}, int'(bus_if.out_valid), 0);
      check({tag, "_overrun"}, int'(bus_if.overrun), 0);
   endtask

   initial begin
      bus_if.flt_rate = 32'd0;
      bus_if.in_l = 16'd0;
      bus_if.in_r = 16'd0;
      set_coef(40'd0, 8'd0, 8'd0, 24'd0);

      // Reset and idle with no rate.
      repeat (3) @(posedge clk);
      #1;
      idle_outputs("reset");
      reset_n = 1'b1;
      repeat (1000) @(posedge clk);
      #1;
      idle_outputs("idle");
      check("idle_stray", stray, 0);

      // Scoreboard phase: one tick every 20 cycles.
      mode = 0;
      set_coef(UNITY, 8'd0, 8'd0, 24'd0);
      bus_if.flt_rate = CLK_RATE / 20;
      next_tick = cyc + 19;
      issue(16'sd1234, -16'sd5678, 16'sd1234, -16'sd5678);
      issue(-16'sd32768, 16'sd0, -16'sd32768, 16'sd0);
      set_coef(UNITY, 8'd2, 8'd1, 24'd0);
      issue(16'sd100, -16'sd50, 16'sd100, -16'sd50);
      issue(16'sd100, -16'sd50, 16'sd300, -16'sd150);
      issue(16'sd10, 16'sd0, 16'sd310, -16'sd150);
      set_coef(UNITY, 8'd0, 8'd0, NEG_ONE);
      issue(16'sd20000, -16'sd20000, 16'sd20000, -16'sd20000);
      issue(16'sd20000, -16'sd20000, 16'sd32767, -16'sd32768);
      issue(16'sd20000, -16'sd20000, 16'sd32767, -16'sd32768);
      issue(16'sd0, 16'sd0, 16'sd32767, -16'sd32768);
      set_coef(DOUBLE, 8'd0, 8'd0, NEG_ONE);
      issue(16'sd10000, -16'sd10000, 16'sd20000, -16'sd20000);
      issue(16'sd10000, -16'sd10000, 16'sd32767, -16'sd32768);
      for (int i = 0; i < 100 && sbq.size() != 0; i++)
         @(posedge clk);
      #1;
      check("sb_drain", sbq.size(), 0);
      bus_if.flt_rate = 32'd0;
      repeat (25) @(posedge clk);
      #1;
      check("sb_overrun", int'(bus_if.overrun), 0);

      // Tick rate: 2000 cycles at 7056000 Hz gives 190 ticks.
      mode = 1;
      pulses = 0;
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      bus_if.flt_rate = 32'd7056000;
      repeat (2000) @(posedge clk);
      #1;
      bus_if.flt_rate = 32'd0;
      repeat (15) @(posedge clk);
      #1;
      check("rate_pulses", pulses, 190);
      check("rate_overrun", int'(bus_if.overrun), 0);

      // Reset mid-computation abandons the sample.
      mode = 3;
      stray = 0;
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      bus_if.flt_rate = CLK_RATE;
      @(posedge clk);
      #1;
      bus_if.flt_rate = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      check("midreset_stray", stray, 0);
      check("midreset_out_l", int'(bus_if.out_l), 0);

      // Overrun: tick every cycle.
      mode = 2;
      pulses = 0;
      @(posedge clk);
      #1;
      bus_if.flt_rate = CLK_RATE;
      c0 = cyc;
      check("overrun_before", int'(bus_if.overrun), 0);
      repeat (2) @(posedge clk);
      #1;
      check("overrun_at_2", int'(bus_if.overrun), 1);
      while (cyc < c0 + 60) begin
         @(posedge clk);
         #1;
      end
      bus_if.flt_rate = 32'd0;
      repeat (15) @(posedge clk);
      #1;
      check("overrun_pulses", pulses, 6);
      check("overrun_sticky", int'(bus_if.overrun), 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_clr_overrun", int'(bus_if.overrun), 0);
      check("async_clr_out_l", int'(bus_if.out_l), 0);
      check("async_clr_out_r", int'(bus_if.out_r), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
